// File: rtl/xcore_pkg.sv
// Shared types for the XCore transmit path: frame width, frame type and the
// transmit-queue handshake states.
package xcore_pkg;

    localparam int FRAME_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK_LOW
    } tx_q_state_t;

    typedef logic [FRAME_W-1:0] xframe_t;

endpackage

// File: rtl/xcore_sync_fifo.sv
// Single-clock FIFO with a combinational head read. The synchronous flush
// empties it and overrides any push or pop in the same cycle.
module xcore_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/xcore_tx_frame_queue.sv
// Frame queue in front of the XSerial transmit channel: buffers frames and
// launches them one at a time over the 4-phase frame_req/frame_ack handshake.
module xcore_tx_frame_queue #(
    parameter int DEPTH   = 4,
    parameter int FRAME_W = 12,
    parameter int CNT_W   = 16
) (
    input  logic                       xbus_clock,
    input  logic                       xbus_reset,
    input  logic [FRAME_W-1:0]         wr_frame,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic                       flush,
    output logic [FRAME_W-1:0]         frame,
    output logic                       frame_req,
    input  logic                       frame_ack,
    input  logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy,
    output logic                       overflow,
    output logic [CNT_W-1:0]           frames_sent
);
    import xcore_pkg::*;

    tx_q_state_t        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   frames_sent_q, frames_sent_d;
    logic [FRAME_W-1:0] fifo_head;
    logic               fifo_full, fifo_empty;
    logic               launch, done;

    xcore_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .clk   (xbus_clock),
        .rst_n (xbus_reset),
        .flush (flush),
        .push  (wr_valid && wr_ready),
        .pop   (launch),
        .din   (wr_frame),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    // A stale ack still high from the previous handshake holds off the launch.
    assign launch = (state_q == IDLE) && !fifo_empty && !halted && !flush && !frame_ack;
    assign done   = (state_q == ACK_LOW) && !frame_ack;

    always_ff @(posedge xbus_clock) begin
        if (!xbus_reset) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch)    state_d = REQ;
            REQ:     if (frame_ack) state_d = ACK_LOW;
            ACK_LOW: if (!frame_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_req = (state_q == REQ);
        busy      = (state_q != IDLE);
    end

    always_comb begin
        frame_d       = launch ? fifo_head : frame_q;
        frames_sent_d = frames_sent_q + CNT_W'(done);
        overflow_d    = overflow_q;
        if (flush)                      overflow_d = 1'b0;
        else if (wr_valid && !wr_ready) overflow_d = 1'b1;
    end

    always_ff @(posedge xbus_clock) begin
        if (!xbus_reset) begin
            frame_q       <= '0;
            overflow_q    <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            frame_q       <= frame_d;
            overflow_q    <= overflow_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign frame       = frame_q;
    assign overflow    = overflow_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_xcore_tx_frame_queue.sv
// Directed bench for xcore_tx_frame_queue: a small ack responder plus
// hand-computed expectations for each scenario.
module tb_xcore_tx_frame_queue;

    localparam int DEPTH   = 4;
    localparam int FRAME_W = 12;
    localparam int CNT_W   = 4;
    localparam int FCW     = $clog2(DEPTH+1);

    logic               xbus_clock = 1'b0;
    logic               xbus_reset;
    logic [FRAME_W-1:0] wr_frame;
    logic               wr_valid;
    logic               wr_ready;
    logic               flush;
    logic [FRAME_W-1:0] frame;
    logic               frame_req;
    logic               frame_ack;
    logic               halted;
    logic [FCW-1:0]     fifo_count;
    logic               busy;
    logic               overflow;
    logic [CNT_W-1:0]   frames_sent;

    int n_checks = 0;
    int n_fail   = 0;

    logic ack_auto = 1'b0;
    logic ack_man  = 1'b0;
    int   ack_dly  = 1;
    int   req_cnt  = 0;

    xcore_tx_frame_queue #(
        .DEPTH   (DEPTH),
        .FRAME_W (FRAME_W),
        .CNT_W   (CNT_W)
    ) dut (
        .xbus_clock  (xbus_clock),
        .xbus_reset  (xbus_reset),
        .wr_frame    (wr_frame),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .flush       (flush),
        .frame       (frame),
        .frame_req   (frame_req),
        .frame_ack   (frame_ack),
        .halted      (halted),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .overflow    (overflow),
        .frames_sent (frames_sent)
    );

    always #5 xbus_clock = ~xbus_clock;

    // Ack responder, driven on the falling edge: raises ack ack_dly cycles
    // into a request and drops it once the request has fallen.
    initial begin
        frame_ack = 1'b0;
        forever begin
            @(negedge xbus_clock);
            if (!ack_auto) begin
                frame_ack = ack_man;
                req_cnt   = 0;
            end else if (frame_req) begin
                req_cnt++;
                if (req_cnt >= ack_dly) frame_ack = 1'b1;
            end else begin
                req_cnt   = 0;
                frame_ack = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge xbus_clock);
        #1;
    endtask

    task automatic do_reset();
        xbus_reset = 1'b0;
        wr_valid   = 1'b0;
        wr_frame   = '0;
        flush      = 1'b0;
        halted     = 1'b0;
        tick();
        tick();
        xbus_reset = 1'b1;
    endtask

    task automatic wr(input logic [FRAME_W-1:0] f);
        wr_valid = 1'b1;
        wr_frame = f;
        tick();
        wr_valid = 1'b0;
        $display("write 0x%03h count=%0d ready=%0d ovf=%0d", f, fifo_count, wr_ready, overflow);
    endtask

    task automatic wait_req(input logic lvl, input string tag);
        int n = 0;
        while (frame_req !== lvl && n < 50) begin
            tick();
            n++;
        end
        check_eq(tag, int'(frame_req), int'(lvl));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (!(busy == 1'b0 && fifo_count == '0) && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, int'(busy), 0);
    endtask

    initial begin
        int reqs;

        // Reset values
        ack_auto = 1'b1;
        ack_dly  = 3;
        do_reset();
        check_eq("rst_count", int'(fifo_count), 0);
        check_eq("rst_ready", int'(wr_ready), 1);
        check_eq("rst_req", int'(frame_req), 0);
        check_eq("rst_frame", int'(frame), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_ovf", int'(overflow), 0);
        check_eq("rst_sent", int'(frames_sent), 0);

        // Single frame, ack 3 cycles after request
        wr(12'hA5C);
        check_eq("t1_count_w", int'(fifo_count), 1);
        check_eq("t1_req_w", int'(frame_req), 0);
        tick();
        check_eq("t1_req_up", int'(frame_req), 1);
        check_eq("t1_frame", int'(frame), 'hA5C);
        check_eq("t1_count_l", int'(fifo_count), 0);
        tick();
        tick();
        check_eq("t1_req_hold", int'(frame_req), 1);
        tick();
        check_eq("t1_req_down", int'(frame_req), 0);
        check_eq("t1_busy_ack", int'(busy), 1);
        tick();
        check_eq("t1_busy_done", int'(busy), 0);
        check_eq("t1_sent", int'(frames_sent), 1);

        // Fill to full, overflow, then drain in order
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++) wr(FRAME_W'(i));
        check_eq("t2_ready", int'(wr_ready), 0);
        check_eq("t2_count", int'(fifo_count), 4);
        check_eq("t2_frame1", int'(frame), 1);
        check_eq("t2_ovf0", int'(overflow), 0);
        wr(12'h006);
        check_eq("t2_ovf1", int'(overflow), 1);
        check_eq("t2_count_ovf", int'(fifo_count), 4);
        ack_auto = 1'b1;
        ack_dly  = 1;
        for (int k = 1; k <= 5; k++) begin
            wait_req(1'b1, "t2_req_up");
            check_eq("t2_order", int'(frame), k);
            $display("launch 0x%03h", frame);
            wait_req(1'b0, "t2_req_down");
        end
        wait_drain("t2_drain");
        check_eq("t2_sent", int'(frames_sent), 5);

        // Halted holds launches and keeps the queue
        do_reset();
        halted = 1'b1;
        wr(12'h111);
        wr(12'h222);
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (frame_req) reqs++;
        end
        check_eq("t3_no_req", reqs, 0);
        check_eq("t3_count", int'(fifo_count), 2);
        halted = 1'b0;
        tick();
        check_eq("t3_req_up", int'(frame_req), 1);
        check_eq("t3_frame", int'(frame), 'h111);
        wait_drain("t3_drain");
        check_eq("t3_sent", int'(frames_sent), 2);

        // Flush during REQ: queue cleared, in-flight completes
        ack_auto = 1'b0;
        ack_man  = 1'b0;
        do_reset();
        wr(12'h010);
        wr(12'h011);
        wr(12'h012);
        wr(12'h013);
        check_eq("t4_req", int'(frame_req), 1);
        check_eq("t4_count3", int'(fifo_count), 3);
        wr(12'h014);
        wr(12'h015);
        check_eq("t4_ovf_set", int'(overflow), 1);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_frame = 12'h099;
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        check_eq("t4_count0", int'(fifo_count), 0);
        check_eq("t4_ovf_clr", int'(overflow), 0);
        check_eq("t4_req_kept", int'(frame_req), 1);
        check_eq("t4_frame_kept", int'(frame), 'h010);
        ack_auto = 1'b1;
        wait_drain("t4_drain");
        check_eq("t4_sent", int'(frames_sent), 1);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (frame_req) reqs++;
        end
        check_eq("t4_no_more", reqs, 0);

        // Stale ack held across reset release blocks launch
        ack_auto = 1'b0;
        ack_man  = 1'b1;
        do_reset();
        wr(12'h0AB);
        for (int i = 0; i < 5; i++) tick();
        check_eq("t5_blocked", int'(frame_req), 0);
        check_eq("t5_count", int'(fifo_count), 1);
        ack_man = 1'b0;
        tick();
        check_eq("t5_req_up", int'(frame_req), 1);
        check_eq("t5_frame", int'(frame), 'h0AB);

        // Reset mid-handshake drops the request
        do_reset();
        check_eq("t5_rst_req", int'(frame_req), 0);
        check_eq("t5_rst_busy", int'(busy), 0);

        // frames_sent wraps modulo 2^CNT_W
        ack_auto = 1'b1;
        ack_dly  = 1;
        for (int i = 0; i < 16; i++) begin
            wr(FRAME_W'(12'h100 + i));
            wait_drain("t6_drain");
            if (i == 14) check_eq("t6_sent15", int'(frames_sent), 15);
        end
        check_eq("t6_wrap", int'(frames_sent), 0);
        check_eq("t6_ovf", int'(overflow), 0);
        check_eq("t6_count", int'(fifo_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xcore_tx_frame_queue.md
Name: xcore_tx_frame_queue

Overview:
- Buffers 12-bit XSerial frames produced by the XCore logic on the XBus clock.
- Presents them one at a time to the XSerial transmit channel using that channel's 4-phase handshake: frame/frame_req/frame_ack.
- Sits directly upstream of the transmit channel. It decouples frame producers from the slower serial line and respects the HALT state.

Parameters:
- DEPTH, 4: number of queued frames, power of 2, minimum 2.
- FRAME_W, 12: frame width in bits. Must match the transmit channel.
- CNT_W, 16: width of the sent-frame counter.

Ports:
- xbus_clock  in  1  XBus clock. All logic is on the rising edge.
- xbus_reset  in  1  synchronous, active-low reset.
- wr_frame  in  FRAME_W  frame to enqueue.
- wr_valid  in  1  enqueue request. Accepted when wr_valid && wr_ready at a clock edge.
- wr_ready  out  1  queue not full.
- flush  in  1  discard all queued, not-yet-launched frames.
- frame  out  FRAME_W  frame to the transmit channel. Stable while frame_req is high.
- frame_req  out  1  transmit request.
- frame_ack  in  1  transmit acknowledge, already in the XBus clock domain.
- halted  in  1  HALT received. Blocks new launches.
- fifo_count  out  $clog2(DEPTH+1)  queued entries, excluding the in-flight frame.
- busy  out  1  handshake in progress (state != IDLE).
- overflow  out  1  sticky: a write was attempted while full.
- frames_sent  out  CNT_W  completed handshakes, wraps modulo 2^CNT_W.

Behaviour:
- Reset (xbus_reset==0 at an edge):
  - FIFO empty; fifo_count=0; wr_ready=1.
  - state=IDLE; frame_req=0; frame=0; busy=0.
  - overflow=0; frames_sent=0.
- Reset mid-handshake drops frame_req immediately after the edge. The in-flight frame is lost.
- FIFO:
  - wr_ready = (fifo_count != DEPTH), combinational from registered count.
  - A write is accepted only if wr_ready is high at the edge. A pop in the same cycle does not free a slot for a write when full.
  - Write and pop in the same cycle (not full): count is unchanged, data ordering is preserved. Pointers wrap modulo DEPTH.
- overflow is set on any edge with wr_valid=1 and wr_ready=0 (and flush=0). It is cleared only by reset or flush.
- FSM states: IDLE, REQ, ACK_LOW.
  - IDLE -> REQ when fifo_count!=0, halted=0, flush=0 and frame_ack=0.
    - On this edge: frame <= FIFO head; head popped; frame_req <= 1.
    - frame_req therefore rises 1 cycle after the edge that wrote into an empty queue.
  - REQ: frame_req=1, frame held.
    - -> ACK_LOW when frame_ack=1; frame_req <= 0 on that edge.
    - halted does not abort REQ; the request waits.
  - ACK_LOW: frame_req=0.
    - -> IDLE when frame_ack=0; frames_sent increments on that edge.
- Minimum spacing: the next launch may occur on the edge after returning to IDLE. Back-to-back frame_req high periods are separated by at least 2 cycles low.
- halted rising while in IDLE: no launch, and queued frames are retained. halted while not in IDLE has no effect until IDLE.
- flush:
  - Clears pointers and count, and clears overflow.
  - A write in the same cycle is discarded and does not set overflow.
  - A launch in the same cycle is suppressed.
  - An in-flight handshake (REQ/ACK_LOW) completes normally and is counted.
- frame_ack high while IDLE (stale) blocks launch until it returns low.
- frame only changes on the IDLE->REQ edge.

Decomposition:
- Package xcore_pkg:
  - FRAME_W=12.
  - typedef enum {IDLE, REQ, ACK_LOW} tx_q_state_t.
  - typedef logic [FRAME_W-1:0] xframe_t.
- One sub-module, xcore_sync_fifo (parameters DEPTH, WIDTH):
  - Single clock, active-low synchronous reset and flush.
  - Ports: push, pop, din, dout (head, combinational read), count, full, empty.
- The FSM, the counters and overflow live in the top module.

Test Plan:
- Reset then write 0xA5C in one cycle, ack model responds 3 cycles after req -> frame_req rises 1 cycle after the write with frame=0xA5C; falls the edge after frame_ack=1; frames_sent=1 after ack drops; fifo_count returns to 0.
- Write 0x001,0x002,0x003,0x004,0x005 on consecutive cycles, ack model holds ack=0 -> first launched (frame=0x001); entries 0x002–0x005 fill DEPTH=4, wr_ready=0 after the fifth write; a sixth write 0x006 sets overflow=1 and is dropped; with ack enabled, frames emerge in order 0x001..0x005 and frames_sent=5.
- halted=1 with 2 frames queued, in IDLE -> no frame_req for 20 cycles, fifo_count=2; halted=0 -> launch on the next edge.
- Assert flush during REQ with 3 queued -> fifo_count=0 the next cycle; the in-flight handshake completes; frames_sent +1; no further req.
- Hold frame_ack=1 across reset release with data queued -> no launch until frame_ack=0, then launch 1 edge later.
- Preload frames_sent near wrap by running 65536 handshakes (or with CNT_W=4, 16 handshakes) -> counter wraps to 0, no other side effects.
